// File: rtl/rr_index_encoder.sv
// rtl/rr_index_encoder.sv - registered 32-to-5 round-robin request encoder with valid/ready grant
// Optional ENC_ONEHOT_OUT_EN adds a registered one-hot copy of the grant.
module rr_index_encoder #(
  parameter int N = 32,
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [N-1:0] req,
  input  logic         grant_ready,
  output logic         grant_valid,
`ifdef ENC_ONEHOT_OUT_EN
  output logic [W-1:0] grant_idx,
  output logic [N-1:0] grant_onehot
`else
  output logic [W-1:0] grant_idx
`endif
);

  logic [W-1:0]   ptr;
  logic           accept;
  logic           load;
  logic [W-1:0]   start;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W-1:0]   sel_off;
  logic [W-1:0]   sel;

  // Rotate so that bit 0 of rot is the search start; lowest set bit wins.
  always_comb begin
    accept  = grant_valid & grant_ready;
    load    = enable & (~grant_valid | grant_ready);
    start   = accept ? grant_idx + 1'b1 : ptr;
    dbl     = {req, req} >> start;
    rot     = dbl[N-1:0];
    sel_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) sel_off = i[W-1:0];
    end
    sel = start + sel_off;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      ptr         <= '0;
    end else begin
      if (load) begin
        if (|req) begin
          grant_idx   <= sel;
          grant_valid <= 1'b1;
        end else begin
          grant_valid <= 1'b0;
        end
      end
      if (accept) ptr <= grant_idx + 1'b1;
    end
  end

`ifdef ENC_ONEHOT_OUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_onehot <= '0;
    end else if (load) begin
      if (|req) grant_onehot <= {{(N-1){1'b0}}, 1'b1} << sel;
      else      grant_onehot <= '0;
    end
  end
`endif

endmodule
